sipo_accum_unit: RTL and testbench
==================================

// Module: sipo_accum_unit
// PURPOSE
//  Parametrised serial-word collector for the SOML decoder datapath. After a start pulse it accepts
//  NUM_WORDS words over a valid/ready handshake, then either sums them (MODE 0) or packs them
//  into one wide vector (MODE 1). The registered result is held behind an out_valid/out_ready handshake.
//  Successor to the fixed 16-bit x 8-cycle accumulator: adds stall tolerance, a result handshake,
//  signed summation, a pack mode and abort/restart handling.
// PARAMETERS
//  DATA_W     16                        width of one input word
//  NUM_WORDS  8                         words per frame, >=2
//  SIGNED     0                         1: sign-extend words before summing
//  ACC_W      DATA_W+$clog2(NUM_WORDS)  sum width; frame sum never overflows
// PORTS
//  clk        in   1                   single clock, rising edge
//  rst        in   1                   asynchronous, active-low reset
//  start      in   1                   1-cycle frame start pulse
//  mode       in   1                   0 = sum, 1 = pack; sampled only on an accepted start
//  in_valid   in   1                   sdi word valid
//  sdi        in   DATA_W              input word
//  in_ready   out  1                   high in COLLECT only
//  out_valid  out  1                   result valid (HOLD state)
//  out_ready  in   1                   consumer accepts result
//  out_sum    out  ACC_W               frame sum (MODE 0), zero in MODE 1
//  out_vec    out  DATA_W*NUM_WORDS    packed words (MODE 1), zero in MODE 0
//  busy       out  1                   state != IDLE
//  err        out  1                   1-cycle pulse: abort or rejected start
// BEHAVIOUR
//  Reset (rst low, async): state IDLE, count 0, acc 0, out_sum 0, out_vec 0, out_valid 0, err 0.
//  FSM IDLE -> COLLECT -> HOLD -> IDLE. All outputs are registered or decoded from state; no latches.
//  IDLE: start=1 -> COLLECT. Clears count/acc/vec and latches mode. The start cycle accepts no data.
//  COLLECT: accept when in_valid && in_ready. Word k (0-based) is added to acc (MODE 0) or written to
//   vec[k*DATA_W +: DATA_W] (MODE 1); word 0 lands in the LSBs. Count advances only on accept, so
//   in_valid gaps stall without loss.
//  On acceptance of word NUM_WORDS-1: state goes to HOLD, the result is registered and out_valid=1 on
//   the next cycle. Latency from last accept to out_valid is 1 clk.
//   Min frame is NUM_WORDS+2 cycles: start, NUM_WORDS accepts, then 1 cycle with out_valid.
//  Sum arithmetic: each word is extended to ACC_W (sign-extended if SIGNED=1, else zero-extended),
//   then accumulated modulo 2^ACC_W. This is exact by construction.
//  HOLD: out_sum/out_vec/out_valid stay stable until out_ready=1. Then the state goes to IDLE and
//   out_valid goes to 0 next cycle. Data outputs keep their last value until the next result load.
//  Start in COLLECT: abort and restart. Count/acc/vec are cleared, mode is re-latched, the state stays
//   COLLECT and err pulses. A word presented that same cycle is discarded.
//  Start in HOLD with out_ready=1: the result is consumed and the state goes directly to COLLECT
//   (back-to-back frames, no err).
//  Start in HOLD with out_ready=0: start is ignored, err pulses and the result is preserved.
//  mode changes outside an accepted start have no effect on the current frame.
//  rst asserted mid-frame: immediate return to reset values; the partial frame is lost, no err.
// STRUCTURE
//  Shared package sipo_pkg: state encodings ST_IDLE=2'd0, ST_COLLECT=2'd1, ST_HOLD=2'd2;
//   MODE_SUM=1'b0, MODE_PACK=1'b1.
//  Sub-module sipo_accum_ctrl: FSM plus word counter. It emits in_ready, accept, last, clear, load and
//   err. The top level holds the datapath (accumulator, pack register, output registers).
// TESTING
//  1 MODE0 SIGNED=0, start then 8 back-to-back words 1..8, out_ready=1
//    -> out_valid 1 clk after word 8, out_sum=36, then IDLE.
//  2 MODE0 SIGNED=1, words 16'hFFFF x8 -> out_sum=19'h7FFF8 (-8); SIGNED=0 -> 19'h7FFF8 vs 0x7FFF8 check
//    unsigned = 524280.
//  3 MODE1, words 16'hA000+k with random in_valid gaps
//    -> out_vec[k*16+:16]=16'hA000+k for k=0..7; count advances only on accepts.
//  4 out_ready=0 for 5 clk in HOLD, start pulsed mid-hold
//    -> outputs stable, err=1 one cycle, result unchanged; then out_ready=1 -> IDLE.
//  5 start after 3 words in COLLECT, then 8 words 2 each
//    -> err pulse, out_sum=16 (first 3 words discarded).
//  6 rst low after 4 words -> all outputs 0 asynchronously, busy=0;
//    a new frame after release completes correctly.

Source files
------------

// File: rtl/sipo_pkg.sv
// Shared types for the serial-word collector.
// State and mode encodings used by control and datapath.
package sipo_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_HOLD    = 2'd2
   } state_t;

   typedef enum logic {
      MODE_SUM  = 1'b0,
      MODE_PACK = 1'b1
   } mode_t;

endpackage

// File: rtl/sipo_accum_unit_if.sv
// Word input and result handshake bundle.
// master drives stimulus, slave is the collector.
interface sipo_accum_unit_if #(
   parameter int DATA_W    = 16,
   parameter int NUM_WORDS = 8,
   parameter int ACC_W     = DATA_W + $clog2(NUM_WORDS)
);

   logic                        start;
   logic                        mode;
   logic                        in_valid;
   logic [DATA_W-1:0]           sdi;
   logic                        in_ready;
   logic                        out_valid;
   logic                        out_ready;
   logic [ACC_W-1:0]            out_sum;
   logic [DATA_W*NUM_WORDS-1:0] out_vec;
   logic                        busy;
   logic                        err;

   modport master (
      output start, mode, in_valid, sdi, out_ready,
      input  in_ready, out_valid, out_sum, out_vec, busy, err
   );

   modport slave (
      input  start, mode, in_valid, sdi, out_ready,
      output in_ready, out_valid, out_sum, out_vec, busy, err
   );

endinterface

// File: rtl/sipo_accum_ctrl.sv
// Frame FSM and word counter.
// Produces accept/clear/load strobes for the datapath.
module sipo_accum_ctrl
   import sipo_pkg::*;
#(
   parameter int NUM_WORDS = 8,
   parameter int CNT_W     = $clog2(NUM_WORDS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic             in_valid_i,
   input  logic             out_ready_i,
   output logic             in_ready_o,
   output logic             accept_o,
   output logic             clear_o,
   output logic             load_o,
   output logic             err_o,
   output logic             busy_o,
   output logic             out_valid_o,
   output logic [CNT_W-1:0] cnt_o
);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
   logic             last;

   // State, counter and error pulse registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   // Next state: start restarts a frame unless a result is stuck in HOLD
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start_i) state_d = ST_COLLECT;
         end
         ST_COLLECT: begin
            if (start_i)   state_d = ST_COLLECT;
            else if (last) state_d = ST_HOLD;
         end
         ST_HOLD: begin
            if (out_ready_i)
               state_d = start_i ? ST_COLLECT : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Strobes, counter update and status decoded from state
   always_comb begin
      in_ready_o  = (state_q == ST_COLLECT);
      accept_o    = in_ready_o && in_valid_i && !start_i;
      last        = accept_o &&
                    (cnt_q == CNT_W'(NUM_WORDS - 1));
      clear_o     = start_i &&
                    ((state_q != ST_HOLD) || out_ready_i);
      load_o      = last;
      err_d       = start_i &&
                    ((state_q == ST_COLLECT) ||
                     ((state_q == ST_HOLD) && !out_ready_i));
      cnt_d       = cnt_q;
      if (clear_o || last) cnt_d = '0;
      else if (accept_o)   cnt_d = cnt_q + CNT_W'(1);
      busy_o      = (state_q != ST_IDLE);
      out_valid_o = (state_q == ST_HOLD);
      err_o       = err_q;
      cnt_o       = cnt_q;
   end

endmodule

// File: rtl/sipo_accum_unit.sv
// Serial-word collector: sums or packs a frame of words.
// Result is registered and held until the consumer takes it.
module sipo_accum_unit
   import sipo_pkg::*;
#(
   parameter int DATA_W    = 16,
   parameter int NUM_WORDS = 8,
   parameter int SIGNED    = 0,
   parameter int ACC_W     = DATA_W + $clog2(NUM_WORDS)
) (
   input logic               clk,
   input logic               rst,
   sipo_accum_unit_if.slave  bus
);

   localparam int CNT_W = $clog2(NUM_WORDS);
   localparam int VEC_W = DATA_W * NUM_WORDS;

   logic             accept, clear, load;
   logic [CNT_W-1:0] cnt;
   mode_t            mode_q;
   logic [ACC_W-1:0] acc_q, acc_d, sum_q, ext;
   logic [VEC_W-1:0] vec_q, vec_d, ovec_q;

   sipo_accum_ctrl #(
      .NUM_WORDS (NUM_WORDS),
      .CNT_W     (CNT_W)
   ) u_ctrl (
      .clk         (clk),
      .rst         (rst),
      .start_i     (bus.start),
      .in_valid_i  (bus.in_valid),
      .out_ready_i (bus.out_ready),
      .in_ready_o  (bus.in_ready),
      .accept_o    (accept),
      .clear_o     (clear),
      .load_o      (load),
      .err_o       (bus.err),
      .busy_o      (bus.busy),
      .out_valid_o (bus.out_valid),
      .cnt_o       (cnt)
   );

   // Candidate accumulator and pack values for the current word
   always_comb begin
      ext = ACC_W'(bus.sdi);
      if (SIGNED != 0) ext = ACC_W'($signed(bus.sdi));
      acc_d = acc_q + ext;
      vec_d = vec_q;
      vec_d[cnt*DATA_W +: DATA_W] = bus.sdi;
   end

   // Working registers and the held result
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mode_q <= MODE_SUM;
         acc_q  <= '0;
         vec_q  <= '0;
         sum_q  <= '0;
         ovec_q <= '0;
      end else begin
         if (clear) begin
            mode_q <= mode_t'(bus.mode);
            acc_q  <= '0;
            vec_q  <= '0;
         end else if (accept) begin
            if (mode_q == MODE_SUM) acc_q <= acc_d;
            else                    vec_q <= vec_d;
         end
         if (load) begin
            sum_q  <= (mode_q == MODE_SUM)  ? acc_d : '0;
            ovec_q <= (mode_q == MODE_PACK) ? vec_d : '0;
         end
      end
   end

   assign bus.out_sum = sum_q;
   assign bus.out_vec = ovec_q;

endmodule

// File: tb/tb_sipo_accum_unit.sv
// Directed bench for sipo_accum_unit.
// Unsigned and signed instances share one stimulus stream.
module tb_sipo_accum_unit;

   localparam int DW = 16;
   localparam int NW = 8;
   localparam int AW = DW + $clog2(NW);

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic          mode = 1'b0;
   logic          in_valid = 1'b0;
   logic [DW-1:0] sdi = '0;
   logic          out_ready = 1'b1;
   int            n_cmp = 0;
   int            n_bad = 0;

   sipo_accum_unit_if #(.DATA_W(DW), .NUM_WORDS(NW)) a_if ();
   sipo_accum_unit_if #(.DATA_W(DW), .NUM_WORDS(NW)) s_if ();

   assign a_if.start     = start;
   assign a_if.mode      = mode;
   assign a_if.in_valid  = in_valid;
   assign a_if.sdi       = sdi;
   assign a_if.out_ready = out_ready;
   assign s_if.start     = start;
   assign s_if.mode      = mode;
   assign s_if.in_valid  = in_valid;
   assign s_if.sdi       = sdi;
   assign s_if.out_ready = out_ready;

   sipo_accum_unit #(.DATA_W(DW), .NUM_WORDS(NW), .SIGNED(0)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (a_if)
   );

   sipo_accum_unit #(.DATA_W(DW), .NUM_WORDS(NW), .SIGNED(1)) u_dut_s (
      .clk (clk),
      .rst (rst),
      .bus (s_if)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs,
                      input logic [127:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_frame(input logic m);
      start = 1'b1;
      mode  = m;
      tick();
      start = 1'b0;
   endtask

   task automatic push(input logic [DW-1:0] w);
      in_valid = 1'b1;
      sdi      = w;
      tick();
      in_valid = 1'b0;
   endtask

   initial begin
      // reset state
      tick();
      chk("rst_valid", a_if.out_valid, 0);
      chk("rst_busy", a_if.busy, 0);
      chk("rst_ready", a_if.in_ready, 0);
      chk("rst_sum", a_if.out_sum, 0);
      chk("rst_vec", a_if.out_vec, 0);
      chk("rst_err", a_if.err, 0);
      tick();
      rst = 1'b1;
      tick();

      // 1: sum of 1..8, one-cycle latency, then idle
      start_frame(1'b0);
      chk("t1_busy", a_if.busy, 1);
      chk("t1_ready", a_if.in_ready, 1);
      for (int k = 1; k <= 7; k++) push(DW'(k));
      chk("t1_nvalid", a_if.out_valid, 0);
      push(16'd8);
      chk("t1_valid", a_if.out_valid, 1);
      chk("t1_sum", a_if.out_sum, 36);
      chk("t1_vec", a_if.out_vec, 0);
      tick();
      chk("t1_idle_v", a_if.out_valid, 0);
      chk("t1_idle_b", a_if.busy, 0);
      chk("t1_keep", a_if.out_sum, 36);

      // 2: all-ones words, then one negative word
      start_frame(1'b0);
      for (int k = 0; k < 8; k++) push(16'hFFFF);
      chk("t2_u_ff", a_if.out_sum, 19'h7FFF8);
      chk("t2_s_ff", s_if.out_sum, 19'h7FFF8);
      tick();
      start_frame(1'b0);
      push(16'h8000);
      for (int k = 1; k < 8; k++) push(16'h0000);
      chk("t2_u_neg", a_if.out_sum, 19'h08000);
      chk("t2_s_neg", s_if.out_sum, 19'h78000);
      tick();

      // 3: pack with gaps; mode toggled mid-frame
      start_frame(1'b1);
      mode = 1'b0;
      for (int k = 0; k < 8; k++) begin
         for (int g = 0; g < k % 3; g++) begin
            tick();
            chk("t3_gap_rdy", a_if.in_ready, 1);
            chk("t3_gap_v", a_if.out_valid, 0);
         end
         push(16'hA000 + DW'(k));
      end
      chk("t3_valid", a_if.out_valid, 1);
      for (int k = 0; k < 8; k++)
         chk($sformatf("t3_w%0d", k),
             a_if.out_vec[k*DW +: DW], 16'hA000 + DW'(k));
      chk("t3_sum0", a_if.out_sum, 0);
      tick();

      // 4: stall in HOLD, rejected start
      out_ready = 1'b0;
      start_frame(1'b0);
      for (int k = 1; k <= 8; k++) push(DW'(k));
      for (int i = 0; i < 5; i++) begin
         start = (i == 2);
         tick();
         start = 1'b0;
         chk("t4_valid", a_if.out_valid, 1);
         chk("t4_sum", a_if.out_sum, 36);
         chk("t4_err", a_if.err, (i == 2));
         chk("t4_rdy", a_if.in_ready, 0);
      end
      out_ready = 1'b1;
      tick();
      chk("t4_rel_v", a_if.out_valid, 0);
      chk("t4_rel_b", a_if.busy, 0);

      // 5: abort after 3 words, mode re-latched
      start_frame(1'b1);
      for (int k = 0; k < 3; k++) push(16'd5);
      start    = 1'b1;
      mode     = 1'b0;
      in_valid = 1'b1;
      sdi      = 16'd100;
      tick();
      start    = 1'b0;
      in_valid = 1'b0;
      chk("t5_err", a_if.err, 1);
      chk("t5_rdy", a_if.in_ready, 1);
      push(16'd2);
      chk("t5_err_off", a_if.err, 0);
      for (int k = 1; k < 8; k++) push(16'd2);
      chk("t5_sum", a_if.out_sum, 16);
      chk("t5_vec", a_if.out_vec, 0);
      start_frame(1'b0);
      chk("t5_b2b_err", a_if.err, 0);
      chk("t5_b2b_rdy", a_if.in_ready, 1);
      chk("t5_b2b_v", a_if.out_valid, 0);
      chk("t5_b2b_sum", a_if.out_sum, 16);

      // 6: async reset mid-frame, then a clean frame
      for (int k = 0; k < 4; k++) push(16'd7);
      rst = 1'b0;
      #1;
      chk("t6_sum", a_if.out_sum, 0);
      chk("t6_valid", a_if.out_valid, 0);
      chk("t6_busy", a_if.busy, 0);
      chk("t6_rdy", a_if.in_ready, 0);
      chk("t6_err", a_if.err, 0);
      tick();
      rst = 1'b1;
      tick();
      start_frame(1'b0);
      for (int k = 10; k <= 17; k++) push(DW'(k));
      chk("t6_valid2", a_if.out_valid, 1);
      chk("t6_sum2", a_if.out_sum, 108);
      tick();
      chk("t6_idle", a_if.busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
